dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Synthesizable responder (slave) end of the core's data-memory req/ready protocol.
- Accepts word read/write requests from CPU_TOP's dmem port and serves them from an internal word array.
- Inserts a programmable fixed wait-state latency before each response.
- Flags out-of-window or misaligned accesses and keeps read/write transaction counters.
- Intended as a local scratchpad/accelerator-buffer target on the dmem bus, alongside the main memory model.

Parameters:
- DWidth, 32, data and address width.
- Depth, 1024, number of DWidth-bit words stored.
- BaseAddr, 32'h00004000, byte address of word 0.
- Latency, 2, cycles from request acceptance to ready_o (legal range 1..15).
- InitFile, "", hex image loaded with $readmemh at time 0 when non-empty.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  request valid; held with addr/write/wdata until ready_o seen.
- write_i  input  1  1 = write, 0 = read.
- addr_i  input  DWidth  byte address.
- wdata_i  input  DWidth  write data.
- ready_o  output  1  one-cycle completion pulse.
- rdata_o  output  DWidth  read data; valid only while ready_o=1, else 0.
- err_o  output  1  pulses with ready_o when the completed access was illegal.
- rd_cnt_o  output  32  completed legal reads.
- wr_cnt_o  output  32  completed legal writes.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state=IDLE; ready_o=0, rdata_o=0, err_o=0, rd_cnt_o=0, wr_cnt_o=0; wait counter=0.
  - Array contents are NOT cleared.
  - Reset mid-transaction abandons it: no write is committed and no ready_o is issued.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_i=1 at edge N latches addr_i, write_i, wdata_i and the legality result; loads the counter with Latency-1 and moves to WAIT. If Latency=1, moves directly to RESP.
  - WAIT: decrements the counter each cycle; moves to RESP when the counter reaches 0.
  - RESP: ready_o=1 for exactly one cycle, so ready_o is high in cycle N+Latency. Next state is IDLE unconditionally.
- Back-to-back requests:
  - A req_i still high in the cycle after ready_o is treated as a new request.
  - Peak throughput is one transaction per Latency+1 cycles.
- Request handling:
  - Request inputs are sampled only in IDLE; changes during WAIT/RESP are ignored.
  - If req_i drops before ready_o, the latched transaction still completes.
- Legality: an access is legal iff addr_i[1:0]==0 and BaseAddr <= addr_i < BaseAddr+Depth*4.
  - Word index = (addr_i-BaseAddr)>>2, computed in DWidth-bit unsigned arithmetic.
  - An address below BaseAddr must not alias via wrap-around.
- Legal read:
  - rdata_o = mem[index] during RESP.
  - Data reflects every write committed before the RESP cycle.
  - rd_cnt_o increments at the end of RESP.
- Legal write:
  - mem[index] <= latched wdata at the end of RESP; rdata_o=0.
  - wr_cnt_o increments at the end of RESP.
  - A read of the same word issued next returns the new value.
- Illegal access:
  - Completes with normal latency; ready_o=1, err_o=1, rdata_o=0.
  - Memory is unchanged and neither counter increments.
- Counters wrap from 32'hFFFFFFFF to 0.
- Outputs are registered: no combinational path from req_i to ready_o.

Test Plan:
- Reset, then write addr 0x4000 data 0xDEADBEEF with Latency=2 → ready_o high exactly 2 cycles after req seen; err_o=0; wr_cnt_o=1. Reading 0x4000 then returns 0xDEADBEEF with rdata_o=0 outside the ready cycle; rd_cnt_o=1.
- Hold req_i high continuously for 4 reads of 0x4000..0x400C (preloaded 1,2,3,4) → ready pulses every 3 cycles with rdata 1,2,3,4; rd_cnt_o=4.
- Read 0x3FFC, 0x4002 and BaseAddr+Depth*4 → each completes with ready_o=1, err_o=1, rdata_o=0; counters unchanged.
- Write 0x4010=0x55 and drop req_i one cycle after acceptance → ready_o still pulses at cycle N+2; mem updated; wr_cnt_o increments.
- Assert rst_i during WAIT of a write of 0xAA to 0x4020 (previously 0x11) → no ready_o; counters 0; a subsequent read of 0x4020 returns 0x11.
- With Latency=1, a read is answered in cycle N+1. Force rd_cnt_o to 32'hFFFFFFFF, then one more read → rd_cnt_o=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/ready bus between a CPU dmem master and a responder.
// The master holds req/addr/write/wdata until it sees the one-cycle ready pulse.
interface dmem_responder_if #(
  parameter int DWidth = 32
);
  logic              req_i;
  logic              write_i;
  logic [DWidth-1:0] addr_i;
  logic [DWidth-1:0] wdata_i;
  logic              ready_o;
  logic [DWidth-1:0] rdata_o;
  logic              err_o;
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output req_i, write_i, addr_i, wdata_i,
    input  ready_o, rdata_o, err_o, rd_cnt_o, wr_cnt_o
  );

  modport slave (
    input  req_i, write_i, addr_i, wdata_i,
    output ready_o, rdata_o, err_o, rd_cnt_o, wr_cnt_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Scratchpad responder on the dmem bus: fixed wait-state latency, window/alignment
// checking, and counters of completed legal reads and writes.
module dmem_responder #(
  parameter int                DWidth   = 32,
  parameter int                Depth    = 1024,
  parameter logic [DWidth-1:0] BaseAddr = 32'h0000_4000,
  parameter int                Latency  = 2,
  parameter string             InitFile = ""
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);
  localparam int                AW       = $clog2(Depth);
  localparam logic [DWidth-1:0] Span     = DWidth'(Depth * 4);
  localparam logic [3:0]        WaitInit = 4'(Latency - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              lat_write, lat_legal;
  logic [AW-1:0]     lat_idx;
  logic [DWidth-1:0] lat_wdata;
  logic [DWidth-1:0] mem [Depth];

  logic              ready_q, err_q;
  logic [DWidth-1:0] rdata_q;
  logic [31:0]       rd_cnt, wr_cnt;
  logic [31:0]       rd_cnt_nxt, wr_cnt_nxt;

  logic [DWidth-1:0] offset;
  logic              legal;
  logic              cur_legal, cur_write;
  logic [AW-1:0]     cur_idx;
  logic              commit_rd, commit_wr;

  // The explicit lower-bound compare keeps addresses below BaseAddr from
  // wrapping into the window through the subtraction.
  assign offset = bus.addr_i - BaseAddr;
  assign legal  = (bus.addr_i[1:0] == 2'b00) && (bus.addr_i >= BaseAddr) && (offset < Span);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_i) state_nxt = (Latency == 1) ? RESP : WAIT;
      WAIT:    if (wait_cnt <= 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With Latency=1 the response is prepared in the same edge that accepts the
  // request, so the live inputs stand in for the latched ones.
  always_comb begin
    cur_legal = lat_legal;
    cur_write = lat_write;
    cur_idx   = lat_idx;
    if (state == IDLE) begin
      cur_legal = legal;
      cur_write = bus.write_i;
      cur_idx   = offset[AW+1:2];
    end
  end

  assign commit_rd  = (state == RESP) && lat_legal && !lat_write;
  assign commit_wr  = (state == RESP) && lat_legal && lat_write;
  assign rd_cnt_nxt = commit_rd ? rd_cnt + 32'd1 : rd_cnt;
  assign wr_cnt_nxt = commit_wr ? wr_cnt + 32'd1 : wr_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_legal <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rd_cnt    <= 32'd0;
      wr_cnt    <= 32'd0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      wr_cnt <= wr_cnt_nxt;
      case (state)
        IDLE:    wait_cnt <= bus.req_i ? WaitInit : 4'd0;
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: wait_cnt <= 4'd0;
      endcase
      if (state == IDLE && bus.req_i) begin
        lat_write <= bus.write_i;
        lat_legal <= legal;
        lat_idx   <= offset[AW+1:2];
        lat_wdata <= bus.wdata_i;
      end
      if (state_nxt == RESP) begin
        ready_q <= 1'b1;
        err_q   <= !cur_legal;
        rdata_q <= (cur_legal && !cur_write) ? mem[cur_idx] : '0;
      end else begin
        ready_q <= 1'b0;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_wr) mem[lat_idx] <= lat_wdata;
  end

  assign bus.ready_o  = ready_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rd_cnt_o = rd_cnt;
  assign bus.wr_cnt_o = wr_cnt;
endmodule
